instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 111 +++++++++++
 tb/tb_instr_mem_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction store with a load phase followed by sequential instruction issue.
// Optional macro INSTR_LOOP_PROG_EN: restart from word 0 at end of program instead of halting.
module instr_mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_en,
    input  logic [5:0]  store_address,
    input  logic [31:0] store_data,
    input  logic        load_done,
    input  logic        next_instr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  prog_len,
    output logic        halted
);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [5:0]  pc;
    logic [5:0]  pc_next;
    logic [6:0]  len_next;
    logic [6:0]  store_end;
    logic        store_hit;
    logic        last_word;
    logic [31:0] mem [64];

    assign store_hit = (state == LOAD) && store_en;
    assign store_end = {1'b0, store_address} + 7'd1;

    // 7-bit compare so that prog_len = 64 terminates at pc = 63 without wrapping
    assign last_word = !(({1'b0, pc} + 7'd1) < prog_len);

    assign halted = (state == HALT);

    always_comb begin
        len_next = prog_len;
        if (store_hit && (store_end > prog_len)) begin
            len_next = store_end;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            LOAD: begin
                if (load_done) begin
                    pc_next    = '0;
                    state_next = (len_next != 7'd0) ? FETCH : HALT;
                end
            end
            FETCH: begin
                state_next = VALID;
            end
            VALID: begin
                if (next_instr) begin
                    if (!last_word) begin
                        pc_next    = pc + 6'd1;
                        state_next = FETCH;
                    end else begin
`ifdef INSTR_LOOP_PROG_EN
                        pc_next    = '0;
                        state_next = FETCH;
`else
                        state_next = HALT;
`endif
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            pc          <= '0;
            prog_len    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            prog_len <= len_next;
            if (state == FETCH) begin
                instr       <= mem[pc];
                instr_valid <= 1'b1;
            end else if ((state == VALID) && next_instr) begin
                instr_valid <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; contents are reloaded after every reset
    always_ff @(posedge clk) begin
        if (store_hit && !reset) begin
            mem[store_address] <= store_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver pushes expected issued words, monitor pops on each new valid word.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        store_en = 1'b0;
    logic [5:0]  store_address = '0;
    logic [31:0] store_data = '0;
    logic        load_done = 1'b0;
    logic        next_instr = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  prog_len;
    logic        halted;

`ifdef INSTR_LOOP_PROG_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    instr_mem_loader dut (
        .clk(clk),
        .reset(reset),
        .store_en(store_en),
        .store_address(store_address),
        .store_data(store_data),
        .load_done(load_done),
        .next_instr(next_instr),
        .instr(instr),
        .instr_valid(instr_valid),
        .prog_len(prog_len),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        bit          known;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mmem [64];
    bit          mknown [64];
    int          mlen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new word is presented whenever instr_valid rises
    initial begin
        logic        pv;
        logic [31:0] pi;
        exp_t        e;
        pv = 1'b0;
        pi = '0;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1 && pv !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no word at %0t", instr, $time);
                end else begin
                    e = sb.pop_front();
                    if (e.known) check("issued_word", instr, e.word);
                end
            end else if (instr_valid === 1'b1 && pv === 1'b1 && !reset) begin
                check("hold_instr", instr, pi);
            end
            pv = instr_valid;
            pi = instr;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mlen = 0;
        for (int i = 0; i < 64; i++) mknown[i] = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_prog_len", {25'b0, prog_len}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_store(input int a, input logic [31:0] d, input bit done);
        store_address = a[5:0];
        store_data    = d;
        store_en      = 1'b1;
        load_done     = done;
        @(negedge clk);
        store_en  = 1'b0;
        load_done = 1'b0;
        mmem[a]   = d;
        mknown[a] = 1'b1;
        if (a + 1 > mlen) mlen = a + 1;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
    endtask

    task automatic after_load();
        exp_t e;
        check("prog_len", {25'b0, prog_len}, mlen);
        check("valid_after_load", {31'b0, instr_valid}, 32'h0);
        check("halted_after_load", {31'b0, halted}, (mlen == 0) ? 32'h1 : 32'h0);
        for (int i = 0; i < mlen; i++) begin
            e.word  = mmem[i];
            e.known = mknown[i];
            sb.push_back(e);
        end
        if (LOOP && mlen > 0) begin
            e.word  = mmem[0];
            e.known = mknown[0];
            sb.push_back(e);
        end
    endtask

    task automatic run_program(input int count, input bit junk);
        int w;
        int h;
        if (junk) begin
            store_en      = 1'b1;
            store_address = 6'd1;
            store_data    = 32'hBAD0_0001;
            next_instr    = 1'b1;
            @(negedge clk);
            store_en   = 1'b0;
            next_instr = 1'b0;
        end
        for (int i = 0; i < count; i++) begin
            w = 0;
            while (instr_valid !== 1'b1 && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (instr_valid !== 1'b1) begin
                check("valid_timeout", {31'b0, instr_valid}, 32'h1);
                return;
            end
            if (i == 0) check("first_latency", w, junk ? 0 : 1);
            h = $urandom_range(0, 3);
            repeat (h) @(negedge clk);
            check("valid_held", {31'b0, instr_valid}, 32'h1);
            next_instr = 1'b1;
            @(negedge clk);
            next_instr = 1'b0;
            check("valid_drop", {31'b0, instr_valid}, 32'h0);
            if (i < count - 1 || LOOP) begin
                @(negedge clk);
                check("one_cycle_gap", {31'b0, instr_valid}, 32'h1);
                check("not_halted", {31'b0, halted}, 32'h0);
            end else begin
                check("halted_end", {31'b0, halted}, 32'h1);
            end
        end
    endtask

    task automatic halt_ignored();
        next_instr    = 1'b1;
        store_en      = 1'b1;
        store_address = 6'd63;
        load_done     = 1'b1;
        repeat (3) @(negedge clk);
        next_instr = 1'b0;
        store_en   = 1'b0;
        load_done  = 1'b0;
        @(negedge clk);
        check("halt_sticky", {31'b0, halted}, 32'h1);
        check("halt_valid_low", {31'b0, instr_valid}, 32'h0);
        check("halt_prog_len", {25'b0, prog_len}, mlen);
    endtask

    initial begin
        int n;
        int w;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_instr", instr, 32'h0);
        check("init_valid", {31'b0, instr_valid}, 32'h0);
        check("init_prog_len", {25'b0, prog_len}, 32'h0);
        check("init_halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // three-word program
        do_store(0, 32'h0000_0013, 1'b0);
        do_store(1, 32'h0010_0093, 1'b0);
        do_store(2, 32'h0020_8113, 1'b0);
        pulse_done();
        after_load();
        run_program(3, 1'b0);
        if (!LOOP) halt_ignored();

        // sparse load
        do_reset();
        do_store(5, 32'hDEAD_BEEF, 1'b1);
        after_load();
        run_program(6, 1'b0);

        // empty program
        do_reset();
        pulse_done();
        after_load();
        repeat (4) begin
            @(negedge clk);
            check("empty_valid", {31'b0, instr_valid}, 32'h0);
            check("empty_halted", {31'b0, halted}, 32'h1);
        end

        // full program, value = address
        do_reset();
        for (int a = 0; a < 64; a++) do_store(a, a, a == 63);
        after_load();
        run_program(64, 1'b0);

        // store with load_done, then ignored strobes during FETCH
        do_reset();
        do_store(0, 32'h1111_2222, 1'b0);
        do_store(1, 32'h3333_4444, 1'b1);
        after_load();
        run_program(2, 1'b1);

        // randomized programs
        repeat (4) begin
            do_reset();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) do_store($urandom_range(0, 63), $urandom, k == n - 1);
            after_load();
            run_program(mlen, 1'b0);
        end

        // reset while a word is valid, then a fresh load
        do_reset();
        do_store(0, 32'hCAFE_0000, 1'b0);
        do_store(3, 32'hCAFE_0003, 1'b1);
        after_load();
        w = 0;
        while (instr_valid !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("midrun_valid", {31'b0, instr_valid}, 32'h1);
        do_reset();
        do_store(0, 32'h0BAD_F00D, 1'b0);
        do_store(1, 32'h1234_5678, 1'b1);
        after_load();
        run_program(2, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
